conv3x3_window_scanner: RTL

- Sits directly downstream of padding_top. Consumes its three padded 418-pixel RGB rows (row0/row1/row2) in one handshake.
- Serialises the rows into 416 consecutive 3x3 windows per colour, one window per accepted beat, for the first conv layer's MAC array.
- Holds a private copy of the three rows, so padding_top can advance its line buffer as soon as the rows are accepted.

---
 rtl/conv3x3_window_scanner.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/conv3x3_window_scanner.sv
// -----------------------------------------------------------------------------
// conv3x3_window_scanner
//
// Purpose:
//   Takes one set of three padded RGB rows (IN_W+2 pixels each) from the
//   padding stage in a single handshake. It keeps a private copy of the rows
//   and then streams IN_W consecutive 3x3 windows per colour, one per accepted
//   beat, to the first convolution layer.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   en                    global enable; 0 freezes the block and hides handshakes
//   row_valid/row_ready   row-set handshake (upstream)
//   {R,G,B}_row{0,1,2}    padded rows; column c is at [c*PIX_W +: PIX_W]
//   {R,G,B}_win           3x3 window; row r, tap k at [(r*3+k)*PIX_W +: PIX_W]
//   win_valid/win_ready   window handshake (downstream)
//   col_idx               output column of the presented window, 0..IN_W-1
//   win_last              presented window is the last one of the row
// -----------------------------------------------------------------------------
module conv3x3_window_scanner #(
  parameter int PIX_W = 8,
  parameter int IN_W  = 416,
  parameter int COL_W = 9
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          row_valid,
  output logic                          row_ready,
  input  logic [(IN_W+2)*PIX_W-1:0]     R_row0,
  input  logic [(IN_W+2)*PIX_W-1:0]     G_row0,
  input  logic [(IN_W+2)*PIX_W-1:0]     B_row0,
  input  logic [(IN_W+2)*PIX_W-1:0]     R_row1,
  input  logic [(IN_W+2)*PIX_W-1:0]     G_row1,
  input  logic [(IN_W+2)*PIX_W-1:0]     B_row1,
  input  logic [(IN_W+2)*PIX_W-1:0]     R_row2,
  input  logic [(IN_W+2)*PIX_W-1:0]     G_row2,
  input  logic [(IN_W+2)*PIX_W-1:0]     B_row2,
  output logic [9*PIX_W-1:0]            R_win,
  output logic [9*PIX_W-1:0]            G_win,
  output logic [9*PIX_W-1:0]            B_win,
  output logic                          win_valid,
  input  logic                          win_ready,
  output logic [COL_W-1:0]              col_idx,
  output logic                          win_last
);

  localparam int ROW_W = (IN_W + 2) * PIX_W;
  localparam int WIN_W = 9 * PIX_W;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IN_W - 1);

  typedef enum logic {IDLE, SCAN} state_e;

  state_e            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              vld_q, vld_d;
  logic              arm_q;
  logic              load_rows;
  logic [ROW_W-1:0]  rbuf_q [3];
  logic [ROW_W-1:0]  gbuf_q [3];
  logic [ROW_W-1:0]  bbuf_q [3];
  logic [WIN_W-1:0]  rwin_q, rwin_d;
  logic [WIN_W-1:0]  gwin_q, gwin_d;
  logic [WIN_W-1:0]  bwin_q, bwin_d;

  // Gather the 3x3 neighbourhood starting at padded column x of three rows.
  function automatic logic [WIN_W-1:0] pick_win(
    input logic [ROW_W-1:0] r0,
    input logic [ROW_W-1:0] r1,
    input logic [ROW_W-1:0] r2,
    input int unsigned      x
  );
    logic [WIN_W-1:0] w;
    w = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      w[k*PIX_W       +: PIX_W] = r0[(x+k)*PIX_W +: PIX_W];
      w[(3+k)*PIX_W   +: PIX_W] = r1[(x+k)*PIX_W +: PIX_W];
      w[(6+k)*PIX_W   +: PIX_W] = r2[(x+k)*PIX_W +: PIX_W];
    end
    return w;
  endfunction

  // arm_q keeps row_ready low until the first clock edge after reset release,
  // so every output reads 0 while reset is held even though en may be 1.
  assign row_ready = (state_q == IDLE) && en && arm_q;
  assign win_valid = (state_q == SCAN) && vld_q && en;
  assign win_last  = win_valid && (col_q == LAST_COL);
  assign col_idx   = col_q;
  assign R_win     = rwin_q;
  assign G_win     = gwin_q;
  assign B_win     = bwin_q;

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    vld_d     = vld_q;
    load_rows = 1'b0;
    rwin_d    = rwin_q;
    gwin_d    = gwin_q;
    bwin_d    = bwin_q;
    case (state_q)
      IDLE: begin
        if (row_valid && row_ready) begin
          // Column 0 comes straight from the inputs; the buffer is only
          // written on this same edge.
          state_d   = SCAN;
          col_d     = '0;
          vld_d     = 1'b1;
          load_rows = 1'b1;
          rwin_d    = pick_win(R_row0, R_row1, R_row2, 0);
          gwin_d    = pick_win(G_row0, G_row1, G_row2, 0);
          bwin_d    = pick_win(B_row0, B_row1, B_row2, 0);
        end
      end
      SCAN: begin
        if (win_valid && win_ready) begin
          if (col_q == LAST_COL) begin
            state_d = IDLE;
            vld_d   = 1'b0;
          end else begin
            col_d  = col_q + COL_W'(1);
            rwin_d = pick_win(rbuf_q[0], rbuf_q[1], rbuf_q[2], 32'(col_q) + 32'd1);
            gwin_d = pick_win(gbuf_q[0], gbuf_q[1], gbuf_q[2], 32'(col_q) + 32'd1);
            bwin_d = pick_win(bbuf_q[0], bbuf_q[1], bbuf_q[2], 32'(col_q) + 32'd1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      vld_q   <= 1'b0;
      arm_q   <= 1'b0;
      rwin_q  <= '0;
      gwin_q  <= '0;
      bwin_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      vld_q   <= vld_d;
      arm_q   <= 1'b1;
      rwin_q  <= rwin_d;
      gwin_q  <= gwin_d;
      bwin_q  <= bwin_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        rbuf_q[i] <= '0;
        gbuf_q[i] <= '0;
        bbuf_q[i] <= '0;
      end
    end else if (load_rows) begin
      rbuf_q[0] <= R_row0;
      rbuf_q[1] <= R_row1;
      rbuf_q[2] <= R_row2;
      gbuf_q[0] <= G_row0;
      gbuf_q[1] <= G_row1;
      gbuf_q[2] <= G_row2;
      bbuf_q[0] <= B_row0;
      bbuf_q[1] <= B_row1;
      bbuf_q[2] <= B_row2;
    end
  end

endmodule
